ram_controller: RTL and testbench

Bus initiator for the 4-bit × 4096 asynchronous RAM in the processor datapath. It accepts single-nibble read and write requests through a valid/ready handshake on the core side. On the RAM side it sequences the chip-select, read/write enable, 12-bit address and bidirectional nibble bus with programmable strobe width. It sits between the processor control unit and the RAM, and is the only driver of the RAM's control pins.

---
 rtl/ram_ctl_pkg.sv | 23 ++
 rtl/ram_ctl_wait_timer.sv | 29 ++
 rtl/ram_controller.sv | 160 ++++++++++++++++
 tb/tb_ram_controller.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_ctl_pkg.sv
// Shared types and constants for the asynchronous nibble-RAM controller.
package ram_ctl_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 4;
    localparam int WAIT_W = 4;

    // Bus levels that leave the RAM neither selected nor driving.
    localparam logic CHIPS_IDLE = 1'b0;
    localparam logic RW_IDLE    = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        W_SETUP,
        W_STROBE,
        W_HOLD,
        R_SETUP,
        R_SELECT,
        R_DRIVE,
        R_RELEASE
    } state_t;

endpackage

// File: rtl/ram_ctl_wait_timer.sv
// Loadable 4-bit down-counter that times both strobe states.
// Loaded with the strobe length on entry; zero marks the final strobe cycle.
module ram_ctl_wait_timer
    import ram_ctl_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_value,
    input  logic              count_en,
    output logic              zero
);

    logic [WAIT_W-1:0] count;

    // Load on strobe entry, otherwise count down and stop at zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count_en && (count != '0)) begin
            count <= count - WAIT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ram_controller.sv
// Bus initiator for the 4-bit x 4096 asynchronous RAM.
// Core side: valid/ready request in, single-cycle rsp_valid out.
// Optional feature macro RAMCTL_BURST_EN adds req_len for multi-beat reads.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; the requester holds req_valid until then.
// rsp_valid is a one-cycle pulse with no backpressure.
module ram_controller
    import ram_ctl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
`ifdef RAMCTL_BURST_EN
    input  logic [3:0]        req_len,
`endif
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              ram_chips,
    output logic              ram_enableRW,
    output logic [ADDR_W-1:0] ram_address,
    inout  wire  [DATA_W-1:0] ram_data,
    output state_t            dbg_state
);

    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_CYCLES);

    state_t            state;
    state_t            state_next;
    logic              accept;
    logic              timer_load;
    logic              timer_en;
    logic              timer_zero;
    logic              drive_data;
    logic              more_beats;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    assign accept = (state == IDLE) && req_valid;

`ifdef RAMCTL_BURST_EN
    logic [3:0] beats_left;

    // Remaining read beats after the current one; writes are always single-beat.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            beats_left <= 4'd0;
        end else if (accept) begin
            beats_left <= req_write ? 4'd0 : req_len;
        end else if ((state == R_RELEASE) && more_beats) begin
            beats_left <= beats_left - 4'd1;
        end
    end

    assign more_beats = (beats_left != 4'd0);
`else
    assign more_beats = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state sequencing of both bus cycles.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (req_valid) state_next = req_write ? W_SETUP : R_SETUP;
            W_SETUP:   state_next = W_STROBE;
            W_STROBE:  if (timer_zero) state_next = W_HOLD;
            W_HOLD:    state_next = IDLE;
            R_SETUP:   state_next = R_SELECT;
            R_SELECT:  if (timer_zero) state_next = R_DRIVE;
            R_DRIVE:   state_next = R_RELEASE;
            R_RELEASE: state_next = more_beats ? R_SELECT : IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Bus and handshake outputs decoded from the current state only.
    always_comb begin
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        ram_chips    = CHIPS_IDLE;
        ram_enableRW = RW_IDLE;
        drive_data   = 1'b0;
        case (state)
            IDLE:      req_ready = 1'b1;
            W_SETUP:   drive_data = 1'b1;
            W_STROBE: begin
                ram_chips  = 1'b1;
                drive_data = 1'b1;
            end
            W_HOLD: begin
                drive_data = 1'b1;
                rsp_valid  = 1'b1;
            end
            R_SETUP:   ;
            R_SELECT: begin
                ram_chips    = 1'b1;
                ram_enableRW = 1'b0;
            end
            R_DRIVE:   ram_enableRW = 1'b0;
            R_RELEASE: rsp_valid = 1'b1;
            default:   ;
        endcase
    end

    // Request capture, read-data capture and burst address stepping.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state == R_DRIVE) begin
                rdata_q <= ram_data;
            end
            if ((state == R_RELEASE) && more_beats) begin
                addr_q <= addr_q + ADDR_W'(1);
            end
        end
    end

    // Strobe timer is loaded on entry into either strobe state.
    assign timer_load = (state_next != state) &&
                        ((state_next == W_STROBE) || (state_next == R_SELECT));
    assign timer_en   = (state == W_STROBE) || (state == R_SELECT);

    ram_ctl_wait_timer u_wait_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (timer_load),
        .load_value (WAIT_LOAD),
        .count_en   (timer_en),
        .zero       (timer_zero)
    );

    assign ram_address = addr_q;
    assign rsp_rdata   = rdata_q;
    assign ram_data    = drive_data ? wdata_q : {DATA_W{1'bz}};
    assign dbg_state   = state;

endmodule

// File: tb/tb_ram_controller.sv
// Self-checking bench for ram_controller.
// Instance 0 (WAIT_CYCLES=1) talks to a behavioural RAM; instances 1 and 2
// (WAIT_CYCLES=0 and 15) sit on pulled-up buses for strobe/latency checks.
// Released buses read 4'hF through the pull-up, so write data is kept below F.
module tb_ram_controller;

    localparam int N = 3;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    logic        req_valid   [N];
    logic        req_write   [N];
    logic [11:0] req_addr    [N];
    logic [3:0]  req_wdata   [N];
    logic [3:0]  req_len     [N];
    logic        req_ready   [N];
    logic        rsp_valid   [N];
    logic [3:0]  rsp_rdata   [N];
    logic        ram_chips   [N];
    logic        ram_rw      [N];
    logic [11:0] ram_address [N];
    ram_ctl_pkg::state_t dbg_state [N];

    tri1 [3:0] bus0;
    tri1 [3:0] bus1;
    tri1 [3:0] bus2;

    int checks = 0;
    int errors = 0;

    // Reference contents: what the core has successfully written.
    logic [3:0] ref_mem [4096];
    bit         ref_ok  [4096];

    ram_controller #(.WAIT_CYCLES(1)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
`ifdef RAMCTL_BURST_EN
        .req_len(req_len[0]),
`endif
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .ram_chips(ram_chips[0]), .ram_enableRW(ram_rw[0]), .ram_address(ram_address[0]),
        .ram_data(bus0), .dbg_state(dbg_state[0])
    );

    ram_controller #(.WAIT_CYCLES(0)) dut_w0 (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
`ifdef RAMCTL_BURST_EN
        .req_len(req_len[1]),
`endif
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .ram_chips(ram_chips[1]), .ram_enableRW(ram_rw[1]), .ram_address(ram_address[1]),
        .ram_data(bus1), .dbg_state(dbg_state[1])
    );

    ram_controller #(.WAIT_CYCLES(15)) dut_w15 (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_write(req_write[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
`ifdef RAMCTL_BURST_EN
        .req_len(req_len[2]),
`endif
        .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]),
        .ram_chips(ram_chips[2]), .ram_enableRW(ram_rw[2]), .ram_address(ram_address[2]),
        .ram_data(bus2), .dbg_state(dbg_state[2])
    );

    // Behavioural asynchronous RAM on bus0, following the bus rules.
    logic [3:0] ram_mem [4096];
    logic [3:0] ram_latch;
    assign bus0 = (!ram_chips[0] && !ram_rw[0]) ? ram_latch : 4'bz;
    always @(posedge clock) begin
        if (ram_chips[0] && ram_rw[0])  ram_mem[ram_address[0]] <= bus0;
        if (ram_chips[0] && !ram_rw[0]) ram_latch <= ram_mem[ram_address[0]];
    end

    function automatic int wait_of(input int i);
        case (i)
            0:       return 1;
            1:       return 0;
            default: return 15;
        endcase
    endfunction

    function automatic logic [3:0] bus_of(input int i);
        case (i)
            0:       return bus0;
            1:       return bus1;
            default: return bus2;
        endcase
    endfunction

    // Drive one request on instance i and record what the bus and core side did.
    // Cycle c is the c-th cycle after the accepting edge.
    task automatic run_txn(input int i, input bit wr, input logic [11:0] a, input logic [3:0] d,
                           output int rsp_c, output int rdy_c, output int strobe_c,
                           output logic [3:0] rdata, output int bad);
        int k;
        logic [3:0] b;
        rsp_c = -1; rdy_c = -1; strobe_c = 0; rdata = 4'h0; bad = 0;
        k = 0;
        while (req_ready[i] !== 1'b1 && k < 50) begin
            @(negedge clock);
            k++;
        end
        req_valid[i] = 1'b1; req_write[i] = wr; req_addr[i] = a; req_wdata[i] = d; req_len[i] = 4'd0;
        @(posedge clock);
        for (int c = 1; c <= 60; c++) begin
            @(negedge clock);
            if (c == 1) req_valid[i] = 1'b0;
            b = bus_of(i);
            if (ram_chips[i] === 1'b1) begin
                strobe_c++;
                if (ram_address[i] !== a) bad++;
                if (wr && (ram_rw[i] !== 1'b1 || b !== d)) bad++;
                if (!wr && (ram_rw[i] !== 1'b0 || b !== 4'hF)) bad++;
            end
            if (rsp_valid[i] === 1'b1 && rsp_c < 0) begin
                rsp_c = c;
                rdata = rsp_rdata[i];
            end
            if (req_ready[i] === 1'b1) begin
                rdy_c = c;
                break;
            end
        end
        req_valid[i] = 1'b0;
    endtask

    task automatic test_reset;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = 0; req_write[i] = 0; req_addr[i] = 0; req_wdata[i] = 0; req_len[i] = 0;
        end
        reset_n = 1'b0;
        #23;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (req_ready[i] !== 1'b1 || rsp_valid[i] !== 1'b0 || ram_chips[i] !== 1'b0 ||
                ram_rw[i] !== 1'b1 || ram_address[i] !== 12'h000 || rsp_rdata[i] !== 4'h0) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: got rdy=%b rsp=%b cs=%b rw=%b addr=%h rdata=%h expected 1 0 0 1 000 0",
                         i, req_ready[i], rsp_valid[i], ram_chips[i], ram_rw[i], ram_address[i], rsp_rdata[i]);
            end
            checks++;
            if (bus_of(i) !== 4'hF) begin
                errors++;
                $display("FAIL reset_bus[%0d]: got %h expected released (F)", i, bus_of(i));
            end
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_write;
        int rsp_c, rdy_c, st, bad;
        logic [3:0] rd;
        run_txn(0, 1'b1, 12'h123, 4'hA, rsp_c, rdy_c, st, rd, bad);
        ref_mem[12'h123] = 4'hA; ref_ok[12'h123] = 1'b1;
        checks++; if (st != 2)     begin errors++; $display("FAIL write_strobe: got %0d expected 2", st); end
        checks++; if (rsp_c != 4)  begin errors++; $display("FAIL write_rsp_cycle: got %0d expected 4", rsp_c); end
        checks++; if (rdy_c != 5)  begin errors++; $display("FAIL write_ready_cycle: got %0d expected 5", rdy_c); end
        checks++; if (bad != 0)    begin errors++; $display("FAIL write_bus: got %0d bad cycles expected 0", bad); end
        checks++;
        if (ram_mem[12'h123] !== 4'hA) begin
            errors++; $display("FAIL write_ram_content: got %h expected a", ram_mem[12'h123]);
        end
    endtask

    task automatic test_read;
        int rsp_c, rdy_c, st, bad;
        logic [3:0] rd;
        run_txn(0, 1'b0, 12'h123, 4'h0, rsp_c, rdy_c, st, rd, bad);
        checks++; if (rd !== 4'hA) begin errors++; $display("FAIL read_data: got %h expected a", rd); end
        checks++; if (rsp_c != 5)  begin errors++; $display("FAIL read_rsp_cycle: got %0d expected 5", rsp_c); end
        checks++; if (rdy_c != 6)  begin errors++; $display("FAIL read_ready_cycle: got %0d expected 6", rdy_c); end
        checks++; if (st != 2)     begin errors++; $display("FAIL read_strobe: got %0d expected 2", st); end
        checks++; if (bad != 0)    begin errors++; $display("FAIL read_bus: got %0d bad cycles expected 0", bad); end
        checks++;
        if (rsp_rdata[0] !== 4'hA) begin
            errors++; $display("FAIL read_data_held: got %h expected a", rsp_rdata[0]);
        end
    endtask

    task automatic test_random;
        int rsp_c, rdy_c, st, bad;
        logic [3:0] rd, d;
        logic [11:0] a;
        bit wr;
        for (int n = 0; n < 24; n++) begin
            wr = ($urandom_range(0, 1) == 1);
            a  = 12'h400 + 12'($urandom_range(0, 7));
            d  = 4'($urandom_range(0, 14));
            run_txn(0, wr, a, d, rsp_c, rdy_c, st, rd, bad);
            checks++;
            if (rsp_c != (wr ? 4 : 5) || rdy_c != (wr ? 5 : 6) || st != 2 || bad != 0) begin
                errors++;
                $display("FAIL rand_timing[%0d]: got rsp=%0d rdy=%0d strobe=%0d bad=%0d expected %0d %0d 2 0",
                         n, rsp_c, rdy_c, st, bad, wr ? 4 : 5, wr ? 5 : 6);
            end
            if (wr) begin
                ref_mem[a] = d; ref_ok[a] = 1'b1;
            end else if (ref_ok[a]) begin
                checks++;
                if (rd !== ref_mem[a]) begin
                    errors++; $display("FAIL rand_read[%0d] @%h: got %h expected %h", n, a, rd, ref_mem[a]);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        int rsp1, rsp2, rdy, bad;
        logic [3:0] d, rd;
        logic [11:0] a;
        a = 12'h200 + 12'($urandom_range(0, 255));
        d = 4'($urandom_range(0, 14));
        rsp1 = -1; rsp2 = -1; rdy = -1; bad = 0; rd = 4'h0;
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = a; req_wdata[0] = d;
        @(posedge clock);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            if (c == 1) req_write[0] = 1'b0;
            if (rdy > 0 && c == rdy + 1) req_valid[0] = 1'b0;
            if (rsp_valid[0] === 1'b1) begin
                if (rsp1 < 0) rsp1 = c;
                else begin rsp2 = c; rd = rsp_rdata[0]; end
            end
            if (req_ready[0] === 1'b1 && rdy < 0) rdy = c;
            if (ram_chips[0] === 1'b1 && ram_rw[0] === 1'b0 && bus0 !== 4'hF) bad++;
            if (rsp2 > 0 && c > rsp2 && req_ready[0] === 1'b1) break;
        end
        req_valid[0] = 1'b0;
        ref_mem[a] = d; ref_ok[a] = 1'b1;
        checks++; if (rdy != 5)   begin errors++; $display("FAIL b2b_accept: got %0d expected 5", rdy); end
        checks++; if (rsp1 != 4)  begin errors++; $display("FAIL b2b_write_rsp: got %0d expected 4", rsp1); end
        checks++; if (rsp2 != 10) begin errors++; $display("FAIL b2b_read_rsp: got %0d expected 10", rsp2); end
        checks++; if (rd !== d)   begin errors++; $display("FAIL b2b_read_data: got %h expected %h", rd, d); end
        checks++; if (bad != 0)   begin errors++; $display("FAIL b2b_bus: got %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_reset_mid_strobe;
        int rsp_c, rdy_c, st, bad;
        logic [3:0] rd;
        ref_ok[12'h300] = 1'b0;
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 12'h300; req_wdata[0] = 4'h5;
        @(posedge clock);
        @(negedge clock);
        req_valid[0] = 1'b0;
        @(negedge clock);
        checks++;
        if (ram_chips[0] !== 1'b1) begin
            errors++; $display("FAIL abort_in_strobe: got cs=%b expected 1", ram_chips[0]);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (ram_chips[0] !== 1'b0 || ram_rw[0] !== 1'b1 || bus0 !== 4'hF || req_ready[0] !== 1'b1 ||
            rsp_valid[0] !== 1'b0 || ram_address[0] !== 12'h000 || rsp_rdata[0] !== 4'h0) begin
            errors++;
            $display("FAIL abort_reset: got cs=%b rw=%b bus=%h rdy=%b rsp=%b addr=%h rdata=%h expected 0 1 f 1 0 000 0",
                     ram_chips[0], ram_rw[0], bus0, req_ready[0], rsp_valid[0], ram_address[0], rsp_rdata[0]);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if (req_ready[0] !== 1'b1 || ram_chips[0] !== 1'b0) begin
            errors++; $display("FAIL abort_idle: got rdy=%b cs=%b expected 1 0", req_ready[0], ram_chips[0]);
        end
        run_txn(0, 1'b0, 12'h123, 4'h0, rsp_c, rdy_c, st, rd, bad);
        checks++;
        if (rd !== ref_mem[12'h123] || rsp_c != 5) begin
            errors++; $display("FAIL abort_recover: got data=%h rsp=%0d expected %h 5", rd, rsp_c, ref_mem[12'h123]);
        end
    endtask

    task automatic test_wait_extremes;
        int rsp_c, rdy_c, st, bad, w;
        logic [3:0] rd, d;
        logic [11:0] a;
        for (int i = 1; i < N; i++) begin
            w = wait_of(i);
            a = 12'($urandom_range(0, 4095));
            d = 4'($urandom_range(0, 14));
            run_txn(i, 1'b1, a, d, rsp_c, rdy_c, st, rd, bad);
            checks++; if (st != w + 1)    begin errors++; $display("FAIL w%0d_write_strobe: got %0d expected %0d", w, st, w + 1); end
            checks++; if (rsp_c != 3 + w) begin errors++; $display("FAIL w%0d_write_rsp: got %0d expected %0d", w, rsp_c, 3 + w); end
            checks++; if (rdy_c != 4 + w) begin errors++; $display("FAIL w%0d_write_ready: got %0d expected %0d", w, rdy_c, 4 + w); end
            checks++; if (bad != 0)       begin errors++; $display("FAIL w%0d_write_bus: got %0d expected 0", w, bad); end
            run_txn(i, 1'b0, a, 4'h0, rsp_c, rdy_c, st, rd, bad);
            checks++; if (st != w + 1)    begin errors++; $display("FAIL w%0d_read_strobe: got %0d expected %0d", w, st, w + 1); end
            checks++; if (rsp_c != 4 + w) begin errors++; $display("FAIL w%0d_read_rsp: got %0d expected %0d", w, rsp_c, 4 + w); end
            checks++; if (rdy_c != 5 + w) begin errors++; $display("FAIL w%0d_read_ready: got %0d expected %0d", w, rdy_c, 5 + w); end
            checks++; if (bad != 0)       begin errors++; $display("FAIL w%0d_read_bus: got %0d expected 0", w, bad); end
        end
    endtask

`ifdef RAMCTL_BURST_EN
    task automatic test_burst;
        int rsp_c, rdy_c, st, bad, pulses;
        logic [3:0] rd;
        logic [11:0] a, ea, strobe_addr;
        for (int k = 0; k < 4; k++) begin
            a = 12'hFFE + 12'(k);
            rd = 4'($urandom_range(0, 14));
            run_txn(0, 1'b1, a, rd, rsp_c, rdy_c, st, rd, bad);
            ref_mem[a] = req_wdata[0]; ref_ok[a] = 1'b1;
        end
        pulses = 0; strobe_addr = 12'h000;
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 12'hFFE; req_len[0] = 4'd3;
        @(posedge clock);
        for (int c = 1; c <= 80; c++) begin
            @(negedge clock);
            if (c == 1) begin req_valid[0] = 1'b0; req_len[0] = 4'd0; end
            if (ram_chips[0] === 1'b1) strobe_addr = ram_address[0];
            if (rsp_valid[0] === 1'b1) begin
                ea = 12'hFFE + 12'(pulses);
                checks++;
                if (rsp_rdata[0] !== ref_mem[ea] || strobe_addr !== ea) begin
                    errors++;
                    $display("FAIL burst_beat[%0d]: got addr=%h data=%h expected %h %h",
                             pulses, strobe_addr, rsp_rdata[0], ea, ref_mem[ea]);
                end
                pulses++;
            end
            if (pulses > 0 && req_ready[0] === 1'b1) break;
        end
        checks++;
        if (pulses != 4) begin errors++; $display("FAIL burst_count: got %0d expected 4", pulses); end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_random();
        test_reset_mid_strobe();
        test_wait_extremes();
`ifdef RAMCTL_BURST_EN
        test_burst();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
